// File: rtl/mu_arbiter.sv
// Two-client arbiter driving the MemoryUnit start/busy handshake.
// Data port has priority; simultaneous requests alternate; a watchdog bounds each transaction.
module mu_arbiter #(
  parameter int unsigned TIMEOUT = 4096,
  localparam int unsigned AW = 27,
  localparam int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_q,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  output logic          d_ack,
  output logic [DW-1:0] d_q,
  output logic          err,
  output logic [AW-1:0] mu_address,
  output logic [DW-1:0] mu_data,
  output logic          mu_we,
  output logic          mu_start,
  input  logic          mu_initDone,
  input  logic          mu_busy,
  input  logic [DW-1:0] mu_q
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t        state, state_nxt;
  logic          grant_d, grant_d_nxt;
  logic          last_d, last_d_nxt;
  logic [CW-1:0] wdog, wdog_nxt, wdog_inc;
  logic [AW-1:0] address_nxt;
  logic [DW-1:0] data_nxt;
  logic          we_nxt;
  logic          start_nxt;
  logic          if_ack_nxt, d_ack_nxt, err_nxt;
  logic [DW-1:0] if_q_nxt, d_q_nxt;
  logic          pick_d;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_d    <= 1'b0;
      last_d     <= 1'b0;
      wdog       <= '0;
      mu_address <= '0;
      mu_data    <= '0;
      mu_we      <= 1'b0;
      mu_start   <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      if_q       <= '0;
      d_q        <= '0;
    end else begin
      state      <= state_nxt;
      grant_d    <= grant_d_nxt;
      last_d     <= last_d_nxt;
      wdog       <= wdog_nxt;
      mu_address <= address_nxt;
      mu_data    <= data_nxt;
      mu_we      <= we_nxt;
      mu_start   <= start_nxt;
      if_ack     <= if_ack_nxt;
      d_ack      <= d_ack_nxt;
      err        <= err_nxt;
      if_q       <= if_q_nxt;
      d_q        <= d_q_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    grant_d_nxt = grant_d;
    last_d_nxt  = last_d;
    wdog_nxt    = wdog;
    address_nxt = mu_address;
    data_nxt    = mu_data;
    we_nxt      = mu_we;
    start_nxt   = mu_start;
    if_ack_nxt  = 1'b0;
    d_ack_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if_q_nxt    = if_q;
    d_q_nxt     = d_q;
    pick_d      = d_req && !(if_req && last_d);
    wdog_inc    = (wdog == CW'(TIMEOUT)) ? wdog : wdog + CW'(1);

    unique case (state)
      IDLE: begin
        if (mu_initDone && (if_req || d_req)) begin
          grant_d_nxt = pick_d;
          last_d_nxt  = pick_d;
          address_nxt = pick_d ? d_addr : if_addr;
          data_nxt    = pick_d ? d_wdata : '0;
          we_nxt      = pick_d && d_we;
          start_nxt   = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        wdog_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        wdog_nxt = wdog_inc;
        // Completion wins over a simultaneous watchdog expiry
        if (!mu_busy) begin
          if (grant_d) begin
            d_ack_nxt = 1'b1;
            if (!mu_we) d_q_nxt = mu_q;
          end else begin
            if_ack_nxt = 1'b1;
            if_q_nxt   = mu_q;
          end
          start_nxt = 1'b0;
          state_nxt = RELEASE;
        end else if (wdog_inc == CW'(TIMEOUT)) begin
          d_ack_nxt  = grant_d;
          if_ack_nxt = !grant_d;
          err_nxt    = 1'b1;
          start_nxt  = 1'b0;
          state_nxt  = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mu_arbiter.sv
// Bench for mu_arbiter: directed protocol scenarios plus randomized two-client traffic,
// scored against a reference memory, a MemoryUnit stub and per-client expectation queues.
`timescale 1ns/1ps
module tb_mu_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [26:0] if_addr;
  logic        if_ack;
  logic [31:0] if_q;
  logic        d_req;
  logic [26:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_ack;
  logic [31:0] d_q;
  logic        err;
  logic [26:0] mu_address;
  logic [31:0] mu_data;
  logic        mu_we;
  logic        mu_start;
  logic        mu_initDone;
  logic        mu_busy;
  logic [31:0] mu_q;

  mu_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_q(if_q),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_ack(d_ack), .d_q(d_q), .err(err),
    .mu_address(mu_address), .mu_data(mu_data), .mu_we(mu_we), .mu_start(mu_start),
    .mu_initDone(mu_initDone), .mu_busy(mu_busy), .mu_q(mu_q)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] q; logic we; } exp_t;
  typedef struct { int start; int lat; logic err; } rec_t;

  exp_t        if_exp[$];
  exp_t        d_exp[$];
  rec_t        rec_q[$];
  bit          grant_log[$];
  logic [31:0] ref_mem [logic [26:0]];
  logic [31:0] stub_mem [logic [26:0]];
  logic [31:0] if_q_m = '0;
  logic [31:0] d_q_m = '0;

  int busy_cfg = 2;
  bit rand_busy = 1'b0;
  bit stuck = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [26:0] a);
    return 32'(a) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] ref_read(input logic [26:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Client request issue: expectation derived from the reference memory at issue time
  task automatic fetch_req(input logic [26:0] a);
    exp_t e;
    e.q = ref_read(a);
    e.we = 1'b0;
    if_exp.push_back(e);
    if_addr = a;
    if_req = 1'b1;
  endtask

  task automatic data_req(input logic [26:0] a, input logic we, input logic [31:0] wd);
    exp_t e;
    e.q = we ? 32'h0 : ref_read(a);
    e.we = we;
    if (we) ref_mem[a] = wd;
    d_exp.push_back(e);
    d_addr = a;
    d_we = we;
    d_wdata = wd;
    d_req = 1'b1;
  endtask

  task automatic wait_ack(input bit is_d);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) begin
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_wait_timeout client=%0d actual=no_ack expected=ack", is_d);
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  // MemoryUnit stub: busy for a configured number of WAIT cycles after each start rise
  initial begin : stub
    bit          prev;
    int          remaining;
    int          n;
    logic [31:0] rdata;
    rec_t        r;
    prev = 1'b0;
    remaining = 0;
    rdata = '0;
    mu_busy = 1'b0;
    mu_q = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        mu_busy = 1'b0;
        continue;
      end
      if (mu_start && !prev) begin
        if (d_req && mu_address == d_addr) begin
          grant_log.push_back(1'b1);
          chk("mu_we_data", 32'(mu_we), 32'(d_we));
          chk("mu_data_data", mu_data, d_wdata);
        end else begin
          grant_log.push_back(1'b0);
          chk("mu_addr_fetch", 32'(mu_address), 32'(if_addr));
          chk("mu_we_fetch", 32'(mu_we), 32'h0);
          chk("mu_data_fetch", mu_data, 32'h0);
        end
        if (mu_we) stub_mem[mu_address] = mu_data;
        rdata = stub_mem.exists(mu_address) ? stub_mem[mu_address] : dflt(mu_address);
        n = stuck ? 100000 : (rand_busy ? int'($urandom_range(0, 6)) : busy_cfg);
        r.start = cyc;
        r.err = (n >= TO);
        r.lat = ((n + 1 > TO) ? TO : n + 1) + 1;
        rec_q.push_back(r);
        remaining = n;
        mu_busy = 1'b1;
        mu_q = $urandom;
      end else if (mu_start) begin
        if (remaining == 0) begin
          mu_busy = 1'b0;
          mu_q = rdata;
        end else begin
          remaining--;
          mu_q = $urandom;
        end
      end else begin
        mu_busy = 1'b0;
      end
      prev = mu_start;
    end
  end

  task automatic handle(input bit is_d);
    exp_t e;
    rec_t r;
    if ((is_d ? d_exp.size() : if_exp.size()) == 0 || rec_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack client=%0d actual=ack expected=none", is_d);
      return;
    end
    if (is_d) e = d_exp.pop_front(); else e = if_exp.pop_front();
    r = rec_q.pop_front();
    chk(is_d ? "d_ack_latency" : "if_ack_latency", 32'(cyc - r.start), 32'(r.lat));
    chk("err_with_ack", 32'(err), 32'(r.err));
    chk("start_low_at_ack", 32'(mu_start), 32'h0);
    if (is_d) begin
      if (!r.err && !e.we) d_q_m = e.q;
      chk("d_q", d_q, d_q_m);
    end else begin
      if (!r.err) if_q_m = e.q;
      chk("if_q", if_q, if_q_m);
    end
  endtask

  // Monitor: scores every ack pulse against the queued expectations
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        if_q_m = '0;
        d_q_m = '0;
        continue;
      end
      if (if_ack && d_ack) chk("dual_ack", 32'h1, 32'h0);
      if (if_ack) handle(1'b0);
      if (d_ack) handle(1'b1);
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL sim_watchdog actual=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    bit seen;
    reset = 1'b1;
    mu_initDone = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mu_start", 32'(mu_start), 32'h0);
    chk("rst_mu_address", 32'(mu_address), 32'h0);
    chk("rst_mu_data", mu_data, 32'h0);
    chk("rst_mu_we", 32'(mu_we), 32'h0);
    chk("rst_if_ack", 32'(if_ack), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_if_q", if_q, 32'h0);
    chk("rst_d_q", d_q, 32'h0);
    reset = 1'b0;

    // Init gating
    busy_cfg = 2;
    data_req(27'h800010, 1'b0, 32'h1111_2222);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (mu_start) seen = 1'b1;
    end
    chk("init_gate_no_start", 32'(seen), 32'h0);
    mu_initDone = 1'b1;
    @(negedge clk);
    chk("start_after_init", 32'(mu_start), 32'h1);
    wait_ack(1'b1);

    // Single fetch with 5 busy cycles
    stub_mem[27'h800007] = 32'hDEADBEEF;
    ref_mem[27'h800007] = 32'hDEADBEEF;
    busy_cfg = 5;
    fetch_req(27'h800007);
    wait_ack(1'b0);
    chk("fetch_deadbeef", if_q, 32'hDEADBEEF);

    // Data write then read
    busy_cfg = 1;
    data_req(27'h800008, 1'b1, 32'h12345678);
    wait_ack(1'b1);
    chk("write_leaves_d_q", d_q, 32'h0000_0000 ^ dflt(27'h800010));
    data_req(27'h800008, 1'b0, 32'hFFFF_0000);
    wait_ack(1'b1);
    chk("read_back", d_q, 32'h12345678);

    // Watchdog expiry, then completion coinciding with the limit, then a normal fetch
    stuck = 1'b1;
    data_req(27'h800020, 1'b0, 32'h0);
    wait_ack(1'b1);
    stuck = 1'b0;
    chk("timeout_d_q_kept", d_q, 32'h12345678);
    busy_cfg = TO - 1;
    data_req(27'h800021, 1'b0, 32'h0);
    wait_ack(1'b1);
    busy_cfg = 0;
    fetch_req(27'h000123);
    wait_ack(1'b0);

    // Data transaction aborted by reset while in WAIT
    stuck = 1'b1;
    data_req(27'h800030, 1'b0, 32'h0);
    for (int i = 0; i < 50 && !mu_start; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_drops_start", 32'(mu_start), 32'h0);
    chk("reset_no_ack", 32'(d_ack), 32'h0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    stuck = 1'b0;
    d_exp.delete();
    rec_q.delete();
    grant_log.delete();
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if_ack || d_ack) seen = 1'b1;
    end
    chk("no_ack_after_abort", 32'(seen), 32'h0);

    // Contention: both clients held continuously for six transactions
    rand_busy = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          fetch_req({1'b0, 26'($urandom)});
          wait_ack(1'b0);
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          data_req({1'b1, 23'd0, 3'($urandom)}, (i == 0), $urandom);
          wait_ack(1'b1);
        end
      end
    join
    chk("grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'((i % 2) == 0));

    // Randomized independent traffic from both clients
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          fetch_req({1'b0, 26'($urandom)});
          wait_ack(1'b0);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          data_req({1'b1, 23'd0, 3'($urandom)}, 1'($urandom), $urandom);
          wait_ack(1'b1);
        end
      end
    join

    repeat (10) @(negedge clk);
    chk("if_exp_drained", 32'(if_exp.size()), 32'h0);
    chk("d_exp_drained", 32'(d_exp.size()), 32'h0);
    chk("rec_drained", 32'(rec_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
